// File: rtl/bus_xfer_pkg.sv
// Shared types for the register-bus transfer controller: FSM encodings, command record, select-width helper.
// No logic and no latency; the imm/data command fields exist only when BUS_XFER_IMM_EN is defined.
// Backpressure: not applicable.
package bus_xfer_pkg;

    localparam int CMD_SEL_W  = 8;
    localparam int CMD_DATA_W = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_TURN  = 2'd3;

    // Indices are held wider than the decoder select so out-of-range requests stay visible.
    typedef struct packed {
        logic [CMD_SEL_W-1:0]  src;
        logic [CMD_SEL_W-1:0]  dst;
`ifdef BUS_XFER_IMM_EN
        logic                  imm;
        logic [CMD_DATA_W-1:0] data;
`endif
    } cmd_t;

    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_xfer_ctrl_onehot_dec.sv
// Select-to-one-hot decoder used for the per-register bus strobes.
// Latency: combinational.
// Backpressure: none; the output is all zeros when en is low.
module onehot_dec #(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [N-1:0]     onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            onehot[i] = en && (sel == SEL_W'(i));
        end
    end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Bus master for register-to-register moves: READ, WRITE, TURN strobe sequence; BUS_XFER_IMM_EN adds immediate loads.
// Latency: an accepted command is in READ the next cycle, WRITE after that, and done pulses in the third.
// Backpressure: a 1-entry buffer; cmd_ready drops while the buffer holds a command.
module bus_xfer_ctrl
    import bus_xfer_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 4,
    localparam int SEL_W   = sel_width(NUM_REGS)
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [SEL_W-1:0]    cmd_src,
    input  logic [SEL_W-1:0]    cmd_dst,
    input  logic [WIDTH-1:0]    bus_in,
    output logic [NUM_REGS-1:0] rd_en,
    output logic [NUM_REGS-1:0] wr_en,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [WIDTH-1:0]    xfer_data,
    output logic [7:0]          xfer_count
`ifdef BUS_XFER_IMM_EN
    ,
    input  logic                cmd_imm,
    input  logic [WIDTH-1:0]    cmd_data,
    output logic [WIDTH-1:0]    imm_bus_out
`endif
);

    logic [1:0] state;
    cmd_t       cur;
    cmd_t       buf_cmd;
    cmd_t       in_cmd;
    logic       buf_valid;
    logic       accept;
    logic       in_ok;
    logic       take;
    logic       in_imm;
    logic       cur_imm;
    logic       rd_act;
    logic       wr_act;

`ifdef BUS_XFER_IMM_EN
    assign in_imm      = cmd_imm;
    assign cur_imm     = cur.imm;
    assign imm_bus_out = (cur.imm && (state == ST_READ || state == ST_WRITE))
                         ? WIDTH'(cur.data) : {WIDTH{1'bz}};
`else
    assign in_imm  = 1'b0;
    assign cur_imm = 1'b0;
`endif

    always_comb begin
        in_cmd     = '0;
        in_cmd.src = CMD_SEL_W'(cmd_src);
        in_cmd.dst = CMD_SEL_W'(cmd_dst);
`ifdef BUS_XFER_IMM_EN
        in_cmd.imm  = cmd_imm;
        in_cmd.data = CMD_DATA_W'(cmd_data);
`endif
    end

    // An immediate load never drives from a register, so its source is not range-checked.
    assign in_ok = (in_cmd.dst < CMD_SEL_W'(NUM_REGS)) &&
                   (in_imm || (in_cmd.src < CMD_SEL_W'(NUM_REGS)));

    assign cmd_ready = ~buf_valid;
    assign accept    = cmd_valid & ~buf_valid;
    assign take      = accept & in_ok;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= ST_IDLE;
            cur        <= '0;
            buf_cmd    <= '0;
            buf_valid  <= 1'b0;
            err        <= 1'b0;
            xfer_data  <= '0;
            xfer_count <= '0;
        end else begin
            err <= accept & ~in_ok;
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        cur   <= in_cmd;
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    state <= ST_WRITE;
                    if (take) begin
                        buf_cmd   <= in_cmd;
                        buf_valid <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    state      <= ST_TURN;
                    xfer_data  <= bus_in;
                    xfer_count <= xfer_count + 8'd1;
                    if (take) begin
                        buf_cmd   <= in_cmd;
                        buf_valid <= 1'b1;
                    end
                end
                ST_TURN: begin
                    // A fresh command on this edge goes straight to READ, skipping IDLE.
                    if (buf_valid) begin
                        cur       <= buf_cmd;
                        buf_valid <= 1'b0;
                        state     <= ST_READ;
                    end else if (take) begin
                        cur   <= in_cmd;
                        state <= ST_READ;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rd_act = (state == ST_READ || state == ST_WRITE) && !cur_imm;
    assign wr_act = (state == ST_WRITE) && (cur_imm || (cur.src != cur.dst));
    assign done   = (state == ST_TURN);
    assign busy   = (state != ST_IDLE) || buf_valid;

    onehot_dec #(.N(NUM_REGS), .SEL_W(SEL_W)) u_rd_dec (
        .sel    (cur.src[SEL_W-1:0]),
        .en     (rd_act),
        .onehot (rd_en)
    );

    onehot_dec #(.N(NUM_REGS), .SEL_W(SEL_W)) u_wr_dec (
        .sel    (cur.dst[SEL_W-1:0]),
        .en     (wr_act),
        .onehot (wr_en)
    );

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed bench for bus_xfer_ctrl: a 4-register instance for the main sequences and a 3-register one for rejects.
// Immediate-load checks are compiled in only when BUS_XFER_IMM_EN is defined.
module tb_bus_xfer_ctrl;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    always #5 clk = ~clk;

    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_src = '0;
    logic [1:0] cmd_dst = '0;
    logic [7:0] bus_in = '0;
    logic [3:0] rd_en, wr_en;
    logic       busy, done, err;
    logic [7:0] xfer_data, xfer_count;

    logic       b_valid = 1'b0;
    logic       b_ready;
    logic [1:0] b_src = '0;
    logic [1:0] b_dst = '0;
    logic [7:0] b_bus = '0;
    logic [2:0] b_rd, b_wr;
    logic       b_busy, b_done, b_err;
    logic [7:0] b_data, b_count;

`ifdef BUS_XFER_IMM_EN
    logic       cmd_imm = 1'b0;
    logic [7:0] cmd_data = '0;
    logic [7:0] imm_bus_out;
    logic       b_imm = 1'b0;
    logic [7:0] b_cdata = '0;
    logic [7:0] b_imm_out;
`endif

    bus_xfer_ctrl #(.WIDTH(8), .NUM_REGS(4)) dut (
        .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .bus_in(bus_in),
        .rd_en(rd_en), .wr_en(wr_en), .busy(busy), .done(done), .err(err),
        .xfer_data(xfer_data), .xfer_count(xfer_count)
`ifdef BUS_XFER_IMM_EN
        , .cmd_imm(cmd_imm), .cmd_data(cmd_data), .imm_bus_out(imm_bus_out)
`endif
    );

    bus_xfer_ctrl #(.WIDTH(8), .NUM_REGS(3)) dut3 (
        .clk(clk), .clr(clr), .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_src(b_src), .cmd_dst(b_dst), .bus_in(b_bus),
        .rd_en(b_rd), .wr_en(b_wr), .busy(b_busy), .done(b_done), .err(b_err),
        .xfer_data(b_data), .xfer_count(b_count)
`ifdef BUS_XFER_IMM_EN
        , .cmd_imm(b_imm), .cmd_data(b_cdata), .imm_bus_out(b_imm_out)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;
    int inv_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!$onehot0(rd_en) || !$onehot0(wr_en) || ((rd_en & wr_en) != 4'b0) ||
            !$onehot0(b_rd) || !$onehot0(b_wr) || ((b_rd & b_wr) != 3'b0))
            inv_bad++;
    end

    typedef struct {
        logic [1:0] src;
        logic [1:0] dst;
        logic [7:0] bus;
        logic [3:0] rd;
        logic [3:0] wr;
    } vec_t;

    typedef struct {
        logic [3:0] rd;
        logic [3:0] wr;
        logic       dn;
        logic       rdy;
    } cyc_t;

    vec_t vecs[4];
    cyc_t b2b[10];
    logic [1:0] q_src[3];
    logic [1:0] q_dst[3];
    int   exp_cnt = 0;

    initial begin
        vecs[0] = '{2'd0, 2'd3, 8'hA5, 4'b0001, 4'b1000};
        vecs[1] = '{2'd2, 2'd2, 8'h3C, 4'b0100, 4'b0000};
        vecs[2] = '{2'd3, 2'd1, 8'h5A, 4'b1000, 4'b0010};
        vecs[3] = '{2'd1, 2'd0, 8'hFF, 4'b0010, 4'b0001};

        b2b[0] = '{4'b0001, 4'b0000, 1'b0, 1'b1};
        b2b[1] = '{4'b0001, 4'b0010, 1'b0, 1'b0};
        b2b[2] = '{4'b0000, 4'b0000, 1'b1, 1'b0};
        b2b[3] = '{4'b0010, 4'b0000, 1'b0, 1'b1};
        b2b[4] = '{4'b0010, 4'b0100, 1'b0, 1'b0};
        b2b[5] = '{4'b0000, 4'b0000, 1'b1, 1'b0};
        b2b[6] = '{4'b0100, 4'b0000, 1'b0, 1'b1};
        b2b[7] = '{4'b0100, 4'b1000, 1'b0, 1'b1};
        b2b[8] = '{4'b0000, 4'b0000, 1'b1, 1'b1};
        b2b[9] = '{4'b0000, 4'b0000, 1'b0, 1'b1};
        q_src[0] = 2'd0; q_dst[0] = 2'd1;
        q_src[1] = 2'd1; q_dst[1] = 2'd2;
        q_src[2] = 2'd2; q_dst[2] = 2'd3;

        // Reset state
        #12;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_data", xfer_data, 0);
        chk("rst_count", xfer_count, 0);
        clr = 1'b0;
        tick();

        // Reset in the middle of a WRITE cycle
        cmd_valid = 1'b1; cmd_src = 2'd1; cmd_dst = 2'd2; bus_in = 8'h77;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("midw_wr_en", wr_en, 4'b0100);
        chk("midw_rd_en", rd_en, 4'b0010);
        #2 clr = 1'b1;
        #1;
        chk("clr_rd_en", rd_en, 0);
        chk("clr_wr_en", wr_en, 0);
        chk("clr_busy", busy, 0);
        #1 clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("clr_no_done", done, 0);
        end
        chk("clr_count", xfer_count, 0);
        chk("clr_data", xfer_data, 0);

        // Single transfers from the vector table
        foreach (vecs[v]) begin
            chk("idle_ready", cmd_ready, 1);
            cmd_valid = 1'b1; cmd_src = vecs[v].src; cmd_dst = vecs[v].dst; bus_in = vecs[v].bus;
            tick();
            cmd_valid = 1'b0;
            chk("read_rd_en", rd_en, vecs[v].rd);
            chk("read_wr_en", wr_en, 0);
            chk("read_done", done, 0);
            tick();
            chk("write_rd_en", rd_en, vecs[v].rd);
            chk("write_wr_en", wr_en, vecs[v].wr);
            tick();
            exp_cnt++;
            chk("turn_rd_en", rd_en, 0);
            chk("turn_wr_en", wr_en, 0);
            chk("turn_done", done, 1);
            chk("turn_data", xfer_data, vecs[v].bus);
            chk("turn_count", xfer_count, exp_cnt);
            tick();
            chk("idle_done", done, 0);
            chk("idle_busy", busy, 0);
        end

        // Three back-to-back commands held valid
        begin
            int idx = 0;
            logic acc;
            cmd_valid = 1'b1; cmd_src = q_src[0]; cmd_dst = q_dst[0]; bus_in = 8'hC3;
            for (int c = 0; c < 10; c++) begin
                acc = cmd_valid & cmd_ready;
                tick();
                if (acc) begin
                    idx++;
                    if (idx < 3) begin
                        cmd_src = q_src[idx]; cmd_dst = q_dst[idx];
                    end else begin
                        cmd_valid = 1'b0;
                    end
                end
                chk("b2b_rd_en", rd_en, b2b[c].rd);
                chk("b2b_wr_en", wr_en, b2b[c].wr);
                chk("b2b_done", done, b2b[c].dn);
                chk("b2b_ready", cmd_ready, b2b[c].rdy);
            end
            exp_cnt += 3;
            chk("b2b_accepted", idx, 3);
            chk("b2b_count", xfer_count, exp_cnt);
            chk("b2b_data", xfer_data, 8'hC3);
            chk("b2b_busy", busy, 0);
        end

        // Out-of-range destination on the 3-register instance
        b_valid = 1'b1; b_src = 2'd0; b_dst = 2'd3;
        tick();
        b_valid = 1'b0;
        chk("bad_err", b_err, 1);
        chk("bad_rd_en", b_rd, 0);
        chk("bad_wr_en", b_wr, 0);
        chk("bad_busy", b_busy, 0);
        tick();
        chk("bad_err_pulse", b_err, 0);
        chk("bad_no_done", b_done, 0);
        chk("bad_count", b_count, 0);
        b_valid = 1'b1; b_src = 2'd3; b_dst = 2'd0;
        tick();
        b_valid = 1'b0;
        chk("bad_src_err", b_err, 1);
        chk("bad_src_rd_en", b_rd, 0);
        b_valid = 1'b1; b_src = 2'd0; b_dst = 2'd2; b_bus = 8'h96;
        tick();
        b_valid = 1'b0;
        chk("ok3_err", b_err, 0);
        chk("ok3_read_rd", b_rd, 3'b001);
        tick();
        chk("ok3_write_rd", b_rd, 3'b001);
        chk("ok3_write_wr", b_wr, 3'b100);
        tick();
        chk("ok3_done", b_done, 1);
        chk("ok3_count", b_count, 1);
        chk("ok3_data", b_data, 8'h96);

`ifdef BUS_XFER_IMM_EN
        // Immediate load of 8'h3C into register 1
        cmd_valid = 1'b1; cmd_imm = 1'b1; cmd_data = 8'h3C; cmd_src = 2'd3; cmd_dst = 2'd1;
        tick();
        cmd_valid = 1'b0; cmd_imm = 1'b0; cmd_data = 8'h00;
        chk("imm_read_out", imm_bus_out, 8'h3C);
        chk("imm_read_rd", rd_en, 0);
        tick();
        chk("imm_write_out", imm_bus_out, 8'h3C);
        chk("imm_write_rd", rd_en, 0);
        chk("imm_write_wr", wr_en, 4'b0010);
        tick();
        exp_cnt++;
        chk("imm_turn_z", (imm_bus_out === 8'hzz), 1);
        chk("imm_done", done, 1);
        chk("imm_count", xfer_count, exp_cnt);
        tick();
`endif

        chk("invariants", inv_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
